// File: rtl/flappy_game_ctrl_if.sv
// Signal bundle between flappy_game_ctrl and its neighbours (debouncer,
// flight_physics, pipe generator, VGA overlay). Clock and reset stay outside.
interface flappy_game_ctrl_if;
    logic        FrameTick;
    logic        BtnPress;
    logic [9:0]  Bird_X_L;
    logic [9:0]  Bird_X_R;
    logic [9:0]  Bird_Y_T;
    logic [9:0]  Bird_Y_B;
    logic [9:0]  Pipe_X_L;
    logic [9:0]  Pipe_X_R;
    logic [9:0]  Gap_Y_T;
    logic [9:0]  Gap_Y_B;
    logic        Phys_q_Stop;
    logic        PhysStart;
    logic        PhysAck;
    logic        PipeRun;
    logic        Flash;
    logic [11:0] Score;
    logic [11:0] HighScore;
    logic        q_Init;
    logic        q_Ready;
    logic        q_Play;
    logic        q_Dying;
    logic        q_Over;

    // Surrounding system drives the frame/button/geometry inputs.
    modport master (
        output FrameTick, BtnPress,
        output Bird_X_L, Bird_X_R, Bird_Y_T, Bird_Y_B,
        output Pipe_X_L, Pipe_X_R, Gap_Y_T, Gap_Y_B, Phys_q_Stop,
        input  PhysStart, PhysAck, PipeRun, Flash, Score, HighScore,
        input  q_Init, q_Ready, q_Play, q_Dying, q_Over
    );

    // The game controller consumes them and drives the sequencing outputs.
    modport slave (
        input  FrameTick, BtnPress,
        input  Bird_X_L, Bird_X_R, Bird_Y_T, Bird_Y_B,
        input  Pipe_X_L, Pipe_X_R, Gap_Y_T, Gap_Y_B, Phys_q_Stop,
        output PhysStart, PhysAck, PipeRun, Flash, Score, HighScore,
        output q_Init, q_Ready, q_Play, q_Dying, q_Over
    );
endinterface

// File: rtl/flappy_game_ctrl.sv
// Flappy-VGA game sequencer: INIT/READY/PLAY/DYING/OVER, per-frame collision and
// BCD scoring. Define HIGHSCORE_EN to build the high-score register and comparator.
module flappy_game_ctrl #(
    parameter logic [9:0] GROUND_Y     = 10'd440,
    parameter logic [7:0] DEATH_FRAMES = 8'd60
) (
    input  logic              Clk,
    input  logic              reset,
    flappy_game_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        S_INIT  = 3'd0,
        S_READY = 3'd1,
        S_PLAY  = 3'd2,
        S_DYING = 3'd3,
        S_OVER  = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [11:0] score_q, score_d;
    logic [7:0]  frame_cnt_q, frame_cnt_d;
    logic        scored_q, scored_d;
    logic        phys_start_q, phys_start_d;
    logic        phys_ack_q, phys_ack_d;

    logic bird_on_ground;
    logic overlap_x;
    logic outside_gap;
    logic hit;
    logic pipe_passed;
    logic pipe_approaching;
    logic score_event;
    logic enter_over;

    // Three-digit BCD increment with per-digit carry, saturating at 999.
    function automatic logic [11:0] bcd_inc(input logic [11:0] v);
        logic [3:0]  d0;
        logic [3:0]  d1;
        logic [3:0]  d2;
        logic [11:0] r;
        d0 = v[3:0];
        d1 = v[7:4];
        d2 = v[11:8];
        if (v == 12'h999) begin
            r = v;
        end else begin
            if (d0 == 4'd9) begin
                d0 = 4'd0;
                if (d1 == 4'd9) begin
                    d1 = 4'd0;
                    d2 = d2 + 4'd1;
                end else begin
                    d1 = d1 + 4'd1;
                end
            end else begin
                d0 = d0 + 4'd1;
            end
            r = {d2, d1, d0};
        end
        return r;
    endfunction

    assign bird_on_ground   = (bus.Bird_Y_B >= GROUND_Y);
    assign overlap_x        = (bus.Bird_X_R >= bus.Pipe_X_L) && (bus.Bird_X_L <= bus.Pipe_X_R);
    assign outside_gap      = (bus.Bird_Y_T < bus.Gap_Y_T) || (bus.Bird_Y_B > bus.Gap_Y_B);
    assign hit              = bird_on_ground || bus.Phys_q_Stop || (overlap_x && outside_gap);
    assign pipe_passed      = (bus.Pipe_X_R < bus.Bird_X_L);
    assign pipe_approaching = !pipe_passed;
    assign score_event      = !hit && pipe_passed && !scored_q;
    assign enter_over       = (state_q == S_DYING) && bus.FrameTick &&
                              (frame_cnt_q == (DEATH_FRAMES - 8'd1));

    // PhysStart/PhysAck are single-cycle pulses registered on the transition edge
    // (READY->PLAY and OVER->INIT); flight_physics samples them without a ready back.
    always_comb begin
        state_d      = state_q;
        score_d      = score_q;
        frame_cnt_d  = frame_cnt_q;
        scored_d     = scored_q;
        phys_start_d = 1'b0;
        phys_ack_d   = 1'b0;
        case (state_q)
            S_INIT: begin
                score_d     = 12'h000;
                frame_cnt_d = 8'd0;
                scored_d    = 1'b0;
                state_d     = S_READY;
            end
            S_READY: begin
                if (bus.BtnPress) begin
                    state_d      = S_PLAY;
                    phys_start_d = 1'b1;
                end
            end
            S_PLAY: begin
                if (bus.FrameTick) begin
                    if (hit) begin
                        state_d     = S_DYING;
                        frame_cnt_d = 8'd0;
                    end else if (score_event) begin
                        score_d  = bcd_inc(score_q);
                        scored_d = 1'b1;
                    end
                    if (pipe_approaching) begin
                        scored_d = 1'b0;
                    end
                end
            end
            S_DYING: begin
                if (bus.FrameTick) begin
                    frame_cnt_d = frame_cnt_q + 8'd1;
                    if (enter_over) begin
                        state_d = S_OVER;
                    end
                end
            end
            S_OVER: begin
                if (bus.BtnPress) begin
                    state_d    = S_INIT;
                    phys_ack_d = 1'b1;
                end
            end
            default: begin
                state_d = S_INIT;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_INIT;
            score_q      <= 12'h000;
            frame_cnt_q  <= 8'd0;
            scored_q     <= 1'b0;
            phys_start_q <= 1'b0;
            phys_ack_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            score_q      <= score_d;
            frame_cnt_q  <= frame_cnt_d;
            scored_q     <= scored_d;
            phys_start_q <= phys_start_d;
            phys_ack_q   <= phys_ack_d;
        end
    end

`ifdef HIGHSCORE_EN
    logic [11:0] high_score_q, high_score_d;

    // Packed BCD orders the same as its decimal value, so a plain compare works.
    always_comb begin
        high_score_d = high_score_q;
        if (enter_over && (score_q > high_score_q)) begin
            high_score_d = score_q;
        end
    end

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            high_score_q <= 12'h000;
        end else begin
            high_score_q <= high_score_d;
        end
    end

    assign bus.HighScore = high_score_q;
`else
    assign bus.HighScore = 12'h000;
`endif

    assign bus.PhysStart = phys_start_q;
    assign bus.PhysAck   = phys_ack_q;
    assign bus.PipeRun   = (state_q == S_PLAY);
    assign bus.Flash     = (state_q == S_DYING) && frame_cnt_q[3];
    assign bus.Score     = score_q;

    assign bus.q_Init    = (state_q == S_INIT);
    assign bus.q_Ready   = (state_q == S_READY);
    assign bus.q_Play    = (state_q == S_PLAY);
    assign bus.q_Dying   = (state_q == S_DYING);
    assign bus.q_Over    = (state_q == S_OVER);

endmodule

// File: doc/flappy_game_ctrl.md
# flappy_game_ctrl

Top-level game sequencer for Flappy-VGA. It drives the Start/Ack handshake of `flight_physics` and gates pipe scrolling. Once per video frame it checks the bird box against the ground and the current pipe pair, and keeps a 3-digit BCD score and high score for the VGA overlay. It sits between the button debouncer, `flight_physics`, the pipe generator and the VGA renderer.

## Interface
Parameters:
- GROUND_Y, 10'd440: bird-bottom row at or below which the bird is dead.
- DEATH_FRAMES, 8'd60: frames spent in DYING before OVER.

Ports:
- Clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- FrameTick  in  1  one-cycle pulse per VGA frame (end of active video).
- BtnPress  in  1  debounced one-cycle button pulse.
- Bird_X_L, Bird_X_R, Bird_Y_T, Bird_Y_B  in  10 each  bird bounding box from `flight_physics`.
- Pipe_X_L, Pipe_X_R  in  10 each  nearest pipe pair, horizontal extent.
- Gap_Y_T, Gap_Y_B  in  10 each  open gap of that pipe pair.
- Phys_q_Stop  in  1  `flight_physics` is in its Stop state.
- PhysStart  out  1  Start pulse to `flight_physics`.
- PhysAck  out  1  Ack pulse to `flight_physics`.
- PipeRun  out  1  pipe scroll enable.
- Flash  out  1  death-flash overlay enable.
- Score  out  12  three BCD digits, [11:8] hundreds.
- HighScore  out  12  three BCD digits.
- q_Init, q_Ready, q_Play, q_Dying, q_Over  out  1 each  one-hot state.

## Operation
- Reset values:
  - state INIT (q_Init=1, other q_* = 0);
  - Score=0, HighScore=0;
  - PhysStart=PhysAck=PipeRun=Flash=0;
  - frame counter 0, scored flag 0.
- INIT:
  - clear Score, frame counter and scored flag;
  - go to READY on the next Clk.
- READY:
  - on BtnPress, go to PLAY;
  - PhysStart=1 for exactly that one transition cycle.
- PLAY:
  - PipeRun=1.
  - Evaluation happens only on cycles with FrameTick=1, using inputs sampled that cycle.
  - hit when any of:
    - Bird_Y_B >= GROUND_Y;
    - Phys_q_Stop=1;
    - overlap: Bird_X_R >= Pipe_X_L and Bird_X_L <= Pipe_X_R, and (Bird_Y_T < Gap_Y_T or Bird_Y_B > Gap_Y_B).
  - Comparisons are unsigned 10-bit.
  - Hit: go to DYING and clear the frame counter.
  - Score event: no hit, Pipe_X_R < Bird_X_L and scored flag=0. Score increments by one in BCD with per-digit carry and saturates at 999; the scored flag is set.
  - Scored flag clears on any FrameTick where Pipe_X_R >= Bird_X_L (a new pipe is approaching).
  - Hit and score event in the same frame: hit wins, Score is unchanged.
  - BtnPress is ignored by this block in PLAY (flaps belong to `flight_physics`).
- DYING:
  - PipeRun=0.
  - Frame counter increments per FrameTick.
  - Flash = counter[3].
  - When the counter reaches DEATH_FRAMES-1 on a FrameTick, go to OVER and set Flash=0.
  - BtnPress is ignored.
- OVER:
  - On entry, if Score > HighScore (BCD compares correctly as unsigned), load HighScore from Score.
  - On BtnPress, go to INIT; PhysAck=1 for exactly that one transition cycle.
- Score persists through DYING and OVER; it is cleared only in INIT.
- reset asserted in any state returns all registers to reset values immediately, including HighScore.

## Timing
- All registers update on the posedge of Clk; reset is async assert and sync-safe deassert.
- READY→PLAY: PhysStart is high during the cycle following the BtnPress edge. q_Play is high from that same edge.
- Collision/score latency: the result is visible on the Clk edge that samples FrameTick=1, i.e. one cycle after the FrameTick cycle begins.
- FrameTick and BtnPress together in READY: BtnPress wins and goes to PLAY; the frame is not evaluated.
- PhysStart and PhysAck are never high together and never high longer than one cycle.
- DYING lasts exactly DEATH_FRAMES FrameTicks.
- HighScore update takes effect on the edge entering OVER.

## Configuration
- HIGHSCORE_EN defined:
  - HighScore register and comparator are present;
  - behaviour as above.
- HIGHSCORE_EN undefined:
  - no HighScore register;
  - HighScore output tied to 12'h000;
  - all other behaviour identical.

## Test plan
- Reset mid-PLAY with Score=12'h005 → q_Init=1, Score=0, HighScore=0, PipeRun=0 immediately on reset low.
- READY with BtnPress pulse → PhysStart high for exactly 1 cycle, q_Play=1, PipeRun=1.
- PLAY, Bird_Y_B=440 on FrameTick → q_Dying=1 next edge. Exactly 60 FrameTicks later q_Over=1 and Flash=0. Flash toggles every 8 frames in between.
- PLAY, pipe sweeps past: Pipe_X_R goes 100→50 with Bird_X_L=60 over two FrameTicks → Score 0→1 once. The score stays 1 on further ticks until Pipe_X_R>=60 again.
- Score preloaded to 12'h099 via 99 pipe passes, then one more → 12'h100. At 999, a further pass holds 12'h999.
- Overlap with Bird_Y_T < Gap_Y_T and a score condition in the same FrameTick → DYING, Score unchanged. In OVER with Score > HighScore → HighScore=Score (12'h000 when HIGHSCORE_EN is undefined). BtnPress → PhysAck 1-cycle pulse, q_Init.
